// File: rtl/regfile_write_buffer.sv
// regfile_write_buffer
//
// Posted-write buffer sitting in front of a register file. Upstream write
// requests are queued in FIFO order and drained into the register file
// whenever the register file grants a write slot (drain_en). Pending writes can
// be looked up by address so readers can forward the youngest queued value.
//
// Ports
//   clk       : single clock, all state updates on the rising edge
//   rst_n     : asynchronous active-low reset, discards every pending entry
//   in_valid  : upstream write request valid
//   in_ready  : buffer can accept a request this cycle (count < DEPTH)
//   in_addr   : target register of the request
//   in_data   : data of the request
//   drain_en  : register file may accept a write this cycle
//   w_en      : write strobe to the register file (drain_en && not empty)
//   w_addr    : register file write address (head entry, 0 when empty)
//   w_data    : register file write data (head entry, 0 when empty)
//   lk_addr   : forwarding lookup address
//   lk_hit    : some occupied entry targets lk_addr
//   lk_data   : data of the youngest occupied entry targeting lk_addr, else 0
//   count     : number of occupied entries

module regfile_write_buffer #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 3,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     w_en,
    output logic [AW-1:0]            w_addr,
    output logic [DW-1:0]            w_data,
    input  logic [AW-1:0]            lk_addr,
    output logic                     lk_hit,
    output logic [DW-1:0]            lk_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Entry storage and FIFO bookkeeping
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push;
    logic pop;
    logic not_empty;

    assign not_empty = (count_q != '0);

    // in_ready depends only on the registered count, so a full buffer stays
    // closed during the cycle it pops and reopens on the following cycle.
    assign in_ready = (count_q < CW'(DEPTH));
    assign w_en     = drain_en && not_empty;

    assign push = in_valid && in_ready;
    assign pop  = w_en;

    // Head entry is presented only while occupied; zeros otherwise so the
    // outputs are clean after reset and between bursts.
    assign w_addr = not_empty ? addr_q[head_q] : '0;
    assign w_data = not_empty ? data_q[head_q] : '0;

    assign count = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        // Pointer width equals log2(DEPTH), so increment wraps DEPTH-1 -> 0.
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else if (push) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    // Forwarding lookup over registered state only. Entries are walked from
    // oldest (head) to youngest, so the last match seen is the youngest one.
    logic [PW-1:0] lk_idx;

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_idx  = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            lk_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_q[lk_idx] == lk_addr)) begin
                lk_hit  = 1'b1;
                lk_data = data_q[lk_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_buffer.sv
module tb_regfile_write_buffer;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 3;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [AW-1:0] lk_addr;
    logic          lk_hit;
    logic [DW-1:0] lk_data;
    logic [2:0]    count;

    int checks   = 0;
    int failures = 0;

    // Expected queue contents: {addr, data}
    logic [AW+DW-1:0] exp_q [$];

    regfile_write_buffer #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .drain_en (drain_en),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One cycle against the queue model: apply inputs, check outputs, clock,
    // then update the model with what should have been pushed/popped.
    task automatic model_cycle(input string tag, input logic v, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic de);
        logic exp_rdy;
        logic exp_wen;
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        drain_en = de;
        #1;
        exp_rdy = (exp_q.size() < DEPTH);
        exp_wen = de && (exp_q.size() != 0);
        check_eq({tag, "_count"}, 32'(count), 32'(exp_q.size()));
        check_eq({tag, "_rdy"}, 32'(in_ready), 32'(exp_rdy));
        check_eq({tag, "_wen"}, 32'(w_en), 32'(exp_wen));
        if (exp_wen) begin
            check_eq({tag, "_waddr"}, 32'(w_addr), 32'(exp_q[0][AW+DW-1:DW]));
            check_eq({tag, "_wdata"}, 32'(w_data), 32'(exp_q[0][DW-1:0]));
        end
        tick();
        if (exp_wen) void'(exp_q.pop_front());
        if (v && exp_rdy) exp_q.push_back({a, d});
    endtask

    initial begin
        int pushes;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        drain_en = 1'b1;
        lk_addr  = '0;

        // Reset state, before any clock edge
        #2;
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_rdy", 32'(in_ready), 32'd1);
        check_eq("rst_wen", 32'(w_en), 32'd0);
        check_eq("rst_lkhit", 32'(lk_hit), 32'd0);
        check_eq("rst_lkdata", 32'(lk_data), 32'd0);
        check_eq("rst_waddr", 32'(w_addr), 32'd0);
        check_eq("rst_wdata", 32'(w_data), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push drains one cycle later, no bypass
        drain_en = 1'b1;
        in_valid = 1'b1;
        in_addr  = 3'd3;
        in_data  = 16'hA5A5;
        #1;
        check_eq("t1_nobypass_wen", 32'(w_en), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("t1_wen", 32'(w_en), 32'd1);
        check_eq("t1_waddr", 32'(w_addr), 32'd3);
        check_eq("t1_wdata", 32'(w_data), 32'hA5A5);
        tick();
        check_eq("t1_count0", 32'(count), 32'd0);
        check_eq("t1_wen0", 32'(w_en), 32'd0);

        // Fill to full, fifth push ignored, then ordered drain
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = AW'(i);
            in_data  = 16'h0010 + 16'(i);
            tick();
        end
        check_eq("t2_count4", 32'(count), 32'd4);
        check_eq("t2_rdy0", 32'(in_ready), 32'd0);
        in_addr = 3'd7;
        in_data = 16'hDEAD;
        tick();
        in_valid = 1'b0;
        lk_addr  = 3'd7;
        #1;
        check_eq("t2_fifth_count", 32'(count), 32'd4);
        check_eq("t2_fifth_lkhit", 32'(lk_hit), 32'd0);
        drain_en = 1'b1;
        #1;
        check_eq("t2_rdy_popcycle", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("t2_wen", 32'(w_en), 32'd1);
            check_eq("t2_waddr", 32'(w_addr), 32'(i));
            check_eq("t2_wdata", 32'(w_data), 32'h0010 + 32'(i));
            tick();
            if (i == 0) check_eq("t2_rdy_after_pop", 32'(in_ready), 32'd1);
        end
        check_eq("t2_empty_count", 32'(count), 32'd0);
        check_eq("t2_empty_wen", 32'(w_en), 32'd0);

        // Full buffer with in_valid held while draining; 12 pushes total wrap
        exp_q.delete();
        pushes = 0;
        for (int i = 0; i < 4; i++) begin
            model_cycle("t3_fill", 1'b1, AW'(pushes), 16'h0100 + 16'(pushes), 1'b0);
            pushes++;
        end
        for (int cyc = 0; cyc < 40 && pushes < 12; cyc++) begin
            if (exp_q.size() < DEPTH) begin
                model_cycle("t3_run", 1'b1, AW'(pushes), 16'h0100 + 16'(pushes), 1'b1);
                pushes++;
            end else begin
                model_cycle("t3_run", 1'b1, AW'(pushes), 16'h0100 + 16'(pushes), 1'b1);
            end
        end
        check_eq("t3_pushes", 32'(pushes), 32'd12);
        for (int cyc = 0; cyc < 6; cyc++) model_cycle("t3_drain", 1'b0, '0, '0, 1'b1);
        check_eq("t3_final_count", 32'(count), 32'd0);

        // Forwarding lookup: youngest match wins, same-cycle push not visible
        drain_en = 1'b0;
        in_valid = 1'b1;
        in_addr  = 3'd5;
        in_data  = 16'h1111;
        tick();
        in_data  = 16'h2222;
        tick();
        in_valid = 1'b0;
        lk_addr  = 3'd5;
        #1;
        check_eq("t4_hit5", 32'(lk_hit), 32'd1);
        check_eq("t4_data5", 32'(lk_data), 32'h2222);
        lk_addr = 3'd6;
        #1;
        check_eq("t4_hit6", 32'(lk_hit), 32'd0);
        check_eq("t4_data6", 32'(lk_data), 32'd0);
        in_valid = 1'b1;
        in_addr  = 3'd6;
        in_data  = 16'h3333;
        #1;
        check_eq("t4_samecycle_hit", 32'(lk_hit), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("t4_next_hit", 32'(lk_hit), 32'd1);
        check_eq("t4_next_data", 32'(lk_data), 32'h3333);
        drain_en = 1'b1;
        lk_addr  = 3'd5;
        tick();
        check_eq("t4_after_pop_hit", 32'(lk_hit), 32'd1);
        check_eq("t4_after_pop_data", 32'(lk_data), 32'h2222);
        check_eq("t4_after_pop_waddr", 32'(w_addr), 32'd5);
        check_eq("t4_after_pop_wdata", 32'(w_data), 32'h2222);
        repeat (2) tick();
        check_eq("t4_empty_count", 32'(count), 32'd0);
        check_eq("t4_empty_hit", 32'(lk_hit), 32'd0);

        // Steady push+pop at count 2
        exp_q.delete();
        model_cycle("t5_fill", 1'b1, 3'd2, 16'hC000, 1'b0);
        model_cycle("t5_fill", 1'b1, 3'd4, 16'hC001, 1'b0);
        for (int i = 0; i < 8; i++) begin
            model_cycle("t5_steady", 1'b1, AW'(i), 16'hC100 + 16'(i), 1'b1);
            check_eq("t5_count2", 32'(count), 32'd2);
        end
        for (int i = 0; i < 3; i++) model_cycle("t5_drain", 1'b0, '0, '0, 1'b1);
        check_eq("t5_final_count", 32'(count), 32'd0);

        // Asynchronous reset mid-operation discards pending entries
        drain_en = 1'b0;
        in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_addr = AW'(i);
            in_data = 16'hE000 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        lk_addr  = 3'd2;
        #1;
        check_eq("t6_pre_count", 32'(count), 32'd3);
        check_eq("t6_pre_hit", 32'(lk_hit), 32'd1);
        drain_en = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_count", 32'(count), 32'd0);
        check_eq("t6_rst_wen", 32'(w_en), 32'd0);
        check_eq("t6_rst_hit", 32'(lk_hit), 32'd0);
        check_eq("t6_rst_waddr", 32'(w_addr), 32'd0);
        tick();
        check_eq("t6_rst_hold_wen", 32'(w_en), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("t6_release_wen", 32'(w_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_post_wen", 32'(w_en), 32'd0);
            check_eq("t6_post_count", 32'(count), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
